iommu_hpm_evt_src: RTL and testbench



---
 rtl/iommu_hpm_evt_src_pkg.sv | 35 +++
 rtl/iommu_hpm_evt_src_edge_pulse.sv | 28 ++
 rtl/iommu_hpm_evt_src.sv | 190 +++++++++++++++++++
 tb/tb_iommu_hpm_evt_src.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/iommu_hpm_evt_src_pkg.sv
// Shared types and widths for the IOMMU HPM event source.
// hpm_evt_t is the snapshot that travels down the output pipeline.
package iommu_hpm_evt_src_pkg;

    localparam int DID_W   = 24;
    localparam int PID_W   = 20;
    localparam int PSCID_W = 20;
    localparam int GSCID_W = 16;
    localparam int N_WALK  = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } evt_state_e;

    typedef struct packed {
        logic               tr_request;
        logic               iotlb_miss;
        logic               ddt_walk;
        logic               pdt_walk;
        logic               s1_ptw;
        logic               s2_ptw;
        logic [DID_W-1:0]   did;
        logic [PID_W-1:0]   pid;
        logic [PSCID_W-1:0] pscid;
        logic [GSCID_W-1:0] gscid;
        logic               pid_v;
    } hpm_evt_t;

    function automatic logic evt_any(input hpm_evt_t e);
        return e.tr_request | e.iotlb_miss | e.ddt_walk |
               e.pdt_walk | e.s1_ptw | e.s2_ptw;
    endfunction

endpackage

// File: rtl/iommu_hpm_evt_src_edge_pulse.sv
// Rising-edge detector over a vector of busy levels.
// While en_i is low the history may only fall, so a level that is high
// when the block becomes live still produces its one pulse.
module iommu_edge_pulse #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] level_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    assign rise_o = level_i & ~prev_q;
    assign prev_d = en_i ? level_i : (prev_q & level_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/iommu_hpm_evt_src.sv
// Turns translation handshakes and walker busy levels into registered,
// single-cycle HPM event pulses tagged with the in-flight translation IDs.
//
// state  | meaning
// IDLE   | no translation in flight; non-request events are orphans
// ACTIVE | translation accepted, events are attributed to captured IDs
module iommu_hpm_evt_src
    import iommu_hpm_evt_src_pkg::*;
#(
    parameter int N_ID_STAGES = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    input  logic               req_ready_i,
    input  logic [DID_W-1:0]   did_i,
    input  logic               pv_i,
    input  logic [PID_W-1:0]   pid_i,
    input  logic               iotlb_access_i,
    input  logic               iotlb_hit_i,
    input  logic               ddtw_busy_i,
    input  logic               pdtw_busy_i,
    input  logic               ctx_valid_i,
    input  logic [GSCID_W-1:0] gscid_i,
    input  logic [PSCID_W-1:0] pscid_i,
    input  logic               s1_busy_i,
    input  logic               s2_busy_i,
    input  logic               trans_done_i,
    output logic               tr_request_o,
    output logic               iotlb_miss_o,
    output logic               ddt_walk_o,
    output logic               pdt_walk_o,
    output logic               s1_ptw_o,
    output logic               s2_ptw_o,
    output logic [DID_W-1:0]   did_o,
    output logic [PID_W-1:0]   pid_o,
    output logic [PSCID_W-1:0] pscid_o,
    output logic [GSCID_W-1:0] gscid_o,
    output logic               pid_v_o,
    output logic               orphan_o
);

    evt_state_e         state_q, state_d;
    logic [DID_W-1:0]   did_q, did_d;
    logic [PID_W-1:0]   pid_q, pid_d;
    logic               pv_q, pv_d;
    logic [PSCID_W-1:0] pscid_q, pscid_d;
    logic [GSCID_W-1:0] gscid_q, gscid_d;
    logic               orphan_q, orphan_d;

    logic               accept;
    logic               new_req;
    logic               live;
    logic               miss_raw;
    logic [N_WALK-1:0]  walk_rise;
    hpm_evt_t           snap;

    assign accept  = req_valid_i & req_ready_i;
    // In ACTIVE a new request is only taken alongside trans_done (back-to-back).
    assign new_req = accept & ((state_q == ST_IDLE) | trans_done_i);
    assign live    = (state_q == ST_ACTIVE) | new_req;
    assign miss_raw = iotlb_access_i & ~iotlb_hit_i;

    iommu_edge_pulse #(
        .W (N_WALK)
    ) u_walk_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (live),
        .level_i ({ddtw_busy_i, pdtw_busy_i, s1_busy_i, s2_busy_i}),
        .rise_o  (walk_rise)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_ACTIVE;
            ST_ACTIVE: if (trans_done_i && !accept) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        did_d   = did_q;
        pid_d   = pid_q;
        pv_d    = pv_q;
        pscid_d = pscid_q;
        gscid_d = gscid_q;
        if (new_req) begin
            did_d   = did_i;
            pid_d   = pid_i;
            pv_d    = pv_i;
            pscid_d = '0;
            gscid_d = '0;
        end
        if (ctx_valid_i && live) begin
            pscid_d = pscid_i;
            gscid_d = gscid_i;
        end
    end

    assign orphan_d = orphan_q | (~live & (miss_raw | (|walk_rise)));

    // The snapshot uses the next-state ID registers so a same-cycle accept or
    // context load is seen by events raised in that cycle.
    always_comb begin
        snap            = '0;
        snap.tr_request = new_req;
        snap.iotlb_miss = miss_raw & live;
        snap.ddt_walk   = walk_rise[3] & live;
        snap.pdt_walk   = walk_rise[2] & live;
        snap.s1_ptw     = walk_rise[1] & live;
        snap.s2_ptw     = walk_rise[0] & live;
        snap.did        = did_d;
        snap.pid        = pid_d;
        snap.pscid      = pscid_d;
        snap.gscid      = gscid_d;
        snap.pid_v      = pv_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            did_q    <= '0;
            pid_q    <= '0;
            pv_q     <= 1'b0;
            pscid_q  <= '0;
            gscid_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            did_q    <= did_d;
            pid_q    <= pid_d;
            pv_q     <= pv_d;
            pscid_q  <= pscid_d;
            gscid_q  <= gscid_d;
            orphan_q <= orphan_d;
        end
    end

    // Event bits advance every cycle; IDs only move with an event so the
    // outputs hold the last attributed context between events.
    for (genvar g = 0; g < N_ID_STAGES; g++) begin : g_stage
        hpm_evt_t q;
        hpm_evt_t d_in;

        if (g == 0) begin : g_first
            assign d_in = snap;
        end else begin : g_next
            assign d_in = g_stage[g-1].q;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q <= '0;
            end else begin
                q.tr_request <= d_in.tr_request;
                q.iotlb_miss <= d_in.iotlb_miss;
                q.ddt_walk   <= d_in.ddt_walk;
                q.pdt_walk   <= d_in.pdt_walk;
                q.s1_ptw     <= d_in.s1_ptw;
                q.s2_ptw     <= d_in.s2_ptw;
                if (evt_any(d_in)) begin
                    q.did   <= d_in.did;
                    q.pid   <= d_in.pid;
                    q.pscid <= d_in.pscid;
                    q.gscid <= d_in.gscid;
                    q.pid_v <= d_in.pid_v;
                end
            end
        end
    end

    hpm_evt_t out_evt;
    assign out_evt = g_stage[N_ID_STAGES-1].q;

    assign tr_request_o = out_evt.tr_request;
    assign iotlb_miss_o = out_evt.iotlb_miss;
    assign ddt_walk_o   = out_evt.ddt_walk;
    assign pdt_walk_o   = out_evt.pdt_walk;
    assign s1_ptw_o     = out_evt.s1_ptw;
    assign s2_ptw_o     = out_evt.s2_ptw;
    assign did_o        = out_evt.did;
    assign pid_o        = out_evt.pid;
    assign pscid_o      = out_evt.pscid;
    assign gscid_o      = out_evt.gscid;
    assign pid_v_o      = out_evt.pid_v;
    assign orphan_o     = orphan_q;

endmodule

// File: tb/tb_iommu_hpm_evt_src.sv
// Directed vector bench for iommu_hpm_evt_src with N_ID_STAGES = 1.
module tb_iommu_hpm_evt_src;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 0, req_ready_i = 0, pv_i = 0;
    logic [23:0] did_i = '0;
    logic [19:0] pid_i = '0, pscid_i = '0;
    logic [15:0] gscid_i = '0;
    logic        iotlb_access_i = 0, iotlb_hit_i = 0, ddtw_busy_i = 0, pdtw_busy_i = 0;
    logic        ctx_valid_i = 0, s1_busy_i = 0, s2_busy_i = 0, trans_done_i = 0;
    logic        tr_request_o, iotlb_miss_o, ddt_walk_o, pdt_walk_o, s1_ptw_o, s2_ptw_o;
    logic [23:0] did_o;
    logic [19:0] pid_o, pscid_o;
    logic [15:0] gscid_o;
    logic        pid_v_o, orphan_o;

    always #5 clk_i = ~clk_i;

    iommu_hpm_evt_src #(.N_ID_STAGES(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_i(req_ready_i),
        .did_i(did_i), .pv_i(pv_i), .pid_i(pid_i),
        .iotlb_access_i(iotlb_access_i), .iotlb_hit_i(iotlb_hit_i),
        .ddtw_busy_i(ddtw_busy_i), .pdtw_busy_i(pdtw_busy_i),
        .ctx_valid_i(ctx_valid_i), .gscid_i(gscid_i), .pscid_i(pscid_i),
        .s1_busy_i(s1_busy_i), .s2_busy_i(s2_busy_i), .trans_done_i(trans_done_i),
        .tr_request_o(tr_request_o), .iotlb_miss_o(iotlb_miss_o),
        .ddt_walk_o(ddt_walk_o), .pdt_walk_o(pdt_walk_o),
        .s1_ptw_o(s1_ptw_o), .s2_ptw_o(s2_ptw_o),
        .did_o(did_o), .pid_o(pid_o), .pscid_o(pscid_o), .gscid_o(gscid_o),
        .pid_v_o(pid_v_o), .orphan_o(orphan_o)
    );

    // ev bit order: {tr_request, iotlb_miss, ddt_walk, pdt_walk, s1_ptw, s2_ptw}
    typedef struct {
        logic        rv, rr, pv, ia, ih, ddt, pdt, ctx, s1, s2, done;
        logic [23:0] did;
        logic [19:0] pid, pscid;
        logic [15:0] gscid;
        logic [5:0]  ev;
        logic [23:0] edid;
        logic [19:0] epid, epscid;
        logic [15:0] egscid;
        logic        epv, eorph;
    } vec_t;

    localparam int NV = 19;
    localparam int SPLIT = 10;
    vec_t vec [NV];
    int n_vec = 0;
    int n_mis = 0;

    function automatic logic [5:0] ev_obs();
        return {tr_request_o, iotlb_miss_o, ddt_walk_o, pdt_walk_o, s1_ptw_o, s2_ptw_o};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid_i = v.rv; req_ready_i = v.rr; did_i = v.did; pv_i = v.pv; pid_i = v.pid;
        iotlb_access_i = v.ia; iotlb_hit_i = v.ih; ddtw_busy_i = v.ddt; pdtw_busy_i = v.pdt;
        ctx_valid_i = v.ctx; gscid_i = v.gscid; pscid_i = v.pscid;
        s1_busy_i = v.s1; s2_busy_i = v.s2; trans_done_i = v.done;
    endtask

    task automatic apply(input int i);
        string nm;
        @(negedge clk_i);
        drive(vec[i]);
        @(posedge clk_i);
        #1;
        nm = $sformatf("vec%0d", i);
        check(nm,
              {ev_obs(), did_o, pid_o, pscid_o, gscid_o, pid_v_o, orphan_o},
              {vec[i].ev, vec[i].edid, vec[i].epid, vec[i].epscid, vec[i].egscid, vec[i].epv, vec[i].eorph});
    endtask

    task automatic idle_inputs();
        vec_t z;
        z = '{default: '0};
        drive(z);
    endtask

    initial begin
        int s1_cnt, ddt_cnt;
        vec[0]  = '{default: '0};
        vec[1]  = '{rv: 1, rr: 1, did: 24'h00ABCD, pv: 1, pid: 20'h12345,
                    ev: 6'b100000, edid: 24'h00ABCD, epid: 20'h12345, epv: 1, default: '0};
        vec[2]  = '{ev: 6'b000000, edid: 24'h00ABCD, epid: 20'h12345, epv: 1, default: '0};
        vec[3]  = '{ctx: 1, gscid: 16'h0042, pscid: 20'h00777, ia: 1, ih: 0,
                    ev: 6'b010000, edid: 24'h00ABCD, epid: 20'h12345, epscid: 20'h00777,
                    egscid: 16'h0042, epv: 1, default: '0};
        vec[4]  = '{ia: 1, ih: 1, edid: 24'h00ABCD, epid: 20'h12345, epscid: 20'h00777,
                    egscid: 16'h0042, epv: 1, default: '0};
        vec[5]  = '{ddt: 1, s2: 1, ev: 6'b001001, edid: 24'h00ABCD, epid: 20'h12345,
                    epscid: 20'h00777, egscid: 16'h0042, epv: 1, default: '0};
        vec[6]  = '{ddt: 1, s2: 1, edid: 24'h00ABCD, epid: 20'h12345,
                    epscid: 20'h00777, egscid: 16'h0042, epv: 1, default: '0};
        vec[7]  = '{edid: 24'h00ABCD, epid: 20'h12345, epscid: 20'h00777,
                    egscid: 16'h0042, epv: 1, default: '0};
        vec[8]  = '{pdt: 1, ev: 6'b000100, edid: 24'h00ABCD, epid: 20'h12345,
                    epscid: 20'h00777, egscid: 16'h0042, epv: 1, default: '0};
        vec[9]  = '{edid: 24'h00ABCD, epid: 20'h12345, epscid: 20'h00777,
                    egscid: 16'h0042, epv: 1, default: '0};
        vec[10] = '{done: 1, rv: 1, rr: 1, did: 24'h000001, ev: 6'b100000,
                    edid: 24'h000001, default: '0};
        vec[11] = '{ia: 1, ev: 6'b010000, edid: 24'h000001, default: '0};
        vec[12] = '{done: 1, edid: 24'h000001, default: '0};
        vec[13] = '{ia: 1, edid: 24'h000001, eorph: 1, default: '0};
        vec[14] = '{edid: 24'h000001, eorph: 1, default: '0};
        vec[15] = '{rv: 1, rr: 1, did: 24'h0000FE, pv: 1, pid: 20'hABCDE, s1: 1,
                    ev: 6'b100010, edid: 24'h0000FE, epid: 20'hABCDE, epv: 1, eorph: 1, default: '0};
        vec[16] = '{s1: 1, edid: 24'h0000FE, epid: 20'hABCDE, epv: 1, eorph: 1, default: '0};
        vec[17] = '{done: 1, edid: 24'h0000FE, epid: 20'hABCDE, epv: 1, eorph: 1, default: '0};
        vec[18] = '{rv: 1, rr: 0, did: 24'h000077, edid: 24'h0000FE, epid: 20'hABCDE,
                    epv: 1, eorph: 1, default: '0};

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", {ev_obs(), did_o, pid_o, pscid_o, gscid_o, pid_v_o, orphan_o}, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < SPLIT; i++) apply(i);

        // s1 high 10, low 1, high 3; ddt high for the first 5 of those cycles
        s1_cnt = 0;
        ddt_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            idle_inputs();
            s1_busy_i   = (c < 10) || (c >= 11 && c < 14);
            ddtw_busy_i = (c < 5);
            @(posedge clk_i);
            #1;
            s1_cnt  += int'(s1_ptw_o);
            ddt_cnt += int'(ddt_walk_o);
        end
        check("s1_pulse_count", 128'(s1_cnt), 128'd2);
        check("ddt_pulse_count", 128'(ddt_cnt), 128'd1);

        for (int i = SPLIT; i < NV; i++) apply(i);

        // Accept with PDT walker rising, then reset while it is still busy.
        @(negedge clk_i);
        idle_inputs();
        req_valid_i = 1; req_ready_i = 1; did_i = 24'h0000AA; pdtw_busy_i = 1;
        @(posedge clk_i);
        #1;
        check("pdt_with_accept", {ev_obs(), did_o}, {6'b100100, 24'h0000AA});
        @(negedge clk_i);
        req_valid_i = 0; req_ready_i = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("async_reset_mid_walk",
              {ev_obs(), did_o, pid_o, pscid_o, gscid_o, pid_v_o, orphan_o}, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_after_reset_no_pulse", {ev_obs(), did_o}, '0);
        @(negedge clk_i);
        req_valid_i = 1; req_ready_i = 1; did_i = 24'h0000BB;
        @(posedge clk_i);
        #1;
        check("busy_through_reset_pulse", {ev_obs(), did_o}, {6'b100100, 24'h0000BB});
        @(negedge clk_i);
        idle_inputs();
        @(posedge clk_i);
        #1;
        check("single_cycle_pulse", {ev_obs(), did_o}, {6'b000000, 24'h0000BB});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
